// File: rtl/imm_decode_pkg.sv
`default_nettype none
// ============================================================================
// imm_decode_pkg : immediate-format codes, RISC-V opcodes, immediate builder
// Rev 1.0
// ============================================================================
package imm_decode_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_Z    = 3'd7
   } imm_type_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Built at 64 bits; callers truncate to XLEN, which yields the correct
   // sign/zero extension for either width. sh6 selects the 6-bit shamt.
   function automatic logic [63:0] build_imm(input logic [31:0] inst,
                                             input imm_type_e imm_type,
                                             input logic sh6);
      logic [63:0] imm;
      imm = '0;
      case (imm_type)
         IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
         IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_SH:  imm = sh6 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
         IMM_Z:   imm = {59'b0, inst[19:15]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_classify.sv
`default_nettype none
// ============================================================================
// imm_classify : combinational format classification and immediate extraction
// Rev 1.0
// ============================================================================
module imm_classify
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [2:0]      imm_type,
   output logic [XLEN-1:0] imm,
   output logic            illegal,
   output logic            sh_arith
);

   localparam logic IS64 = (XLEN == 64);

   logic [6:0] opcode;
   logic [2:0] funct3;
   imm_type_e  type_c;
   logic       illegal_c;
   logic       shift_c;
   logic       sh6_c;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];

   always_comb begin
      type_c    = IMM_NONE;
      illegal_c = 1'b0;
      shift_c   = 1'b0;
      sh6_c     = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC:                 type_c = IMM_U;
         OPC_JAL:                            type_c = IMM_J;
         OPC_JALR, OPC_LOAD, OPC_MISC_MEM:   type_c = IMM_I;
         OPC_STORE:                          type_c = IMM_S;
         OPC_BRANCH:                         type_c = IMM_B;
         OPC_OP_IMM: begin
            shift_c = (funct3 == 3'b001) || (funct3 == 3'b101);
            sh6_c   = IS64;
            type_c  = shift_c ? IMM_SH : IMM_I;
         end
         OPC_OP_IMM_32: begin
            if (IS64) begin
               shift_c = (funct3 == 3'b001) || (funct3 == 3'b101);
               type_c  = shift_c ? IMM_SH : IMM_I;
            end else begin
               illegal_c = 1'b1;
            end
         end
         OPC_OP:                             type_c = IMM_NONE;
         OPC_OP_32:                          illegal_c = !IS64;
         OPC_SYSTEM:                         type_c = funct3[2] ? IMM_Z : IMM_I;
         default:                            illegal_c = 1'b1;
      endcase

      if (inst[1:0] != 2'b11) begin
         illegal_c = 1'b1;
      end
      // inst[25] is a shamt bit only for the 6-bit form
      if (shift_c && (inst[31] || (|inst[29:26]) || (!sh6_c && inst[25]))) begin
         illegal_c = 1'b1;
      end
      if (illegal_c) begin
         type_c = IMM_NONE;
      end
   end

   assign imm_type = type_c;
   assign imm      = XLEN'(build_imm(inst, type_c, sh6_c));
   assign illegal  = illegal_c;
   assign sh_arith = shift_c && !illegal_c && inst[30];

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// imm_decode_stage : registered immediate/field decode with 2-entry output skid
// Rev 1.0
// ============================================================================
module imm_decode_stage
   import imm_decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_imm_type,
   output logic [6:0]       out_opcode,
   output logic [2:0]       out_funct3,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_sh_arith,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      imm_type;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            sh_arith;
      logic            illegal;
   } entry_t;

   logic [2:0]      dec_type;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;
   logic            dec_sh_arith;
   entry_t          new_entry;

   logic             out_valid_q, out_valid_d;
   entry_t           out_q, out_d;
   logic             skid_valid_q, skid_valid_d;
   entry_t           skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic consume;

   imm_classify #(
      .XLEN (XLEN)
   ) u_classify (
      .inst     (in_inst),
      .imm_type (dec_type),
      .imm      (dec_imm),
      .illegal  (dec_illegal),
      .sh_arith (dec_sh_arith)
   );

   always_comb begin
      new_entry.pc       = in_pc;
      new_entry.imm      = dec_imm;
      new_entry.imm_type = dec_type;
      new_entry.opcode   = in_inst[6:0];
      new_entry.funct3   = in_inst[14:12];
      new_entry.rd       = in_inst[11:7];
      new_entry.rs1      = in_inst[19:15];
      new_entry.rs2      = in_inst[24:20];
      new_entry.sh_arith = dec_sh_arith;
      new_entry.illegal  = dec_illegal;
   end

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
   assign in_ready = !skid_valid_q;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      cnt_d        = cnt_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (accept && new_entry.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (skid_valid_q) begin
            // Full: nothing can be accepted, only the skid can advance.
            if (consume) begin
               out_d        = skid_q;
               skid_valid_d = 1'b0;
            end
         end else if (!out_valid_q || consume) begin
            out_valid_d = accept;
            if (accept) begin
               out_d = new_entry;
            end
         end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = new_entry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_q.pc;
   assign out_imm      = out_q.imm;
   assign out_imm_type = out_q.imm_type;
   assign out_opcode   = out_q.opcode;
   assign out_funct3   = out_q.funct3;
   assign out_rd       = out_q.rd;
   assign out_rs1      = out_q.rs1;
   assign out_rs2      = out_q.rs2;
   assign out_sh_arith = out_q.sh_arith;
   assign out_illegal  = out_q.illegal;
   assign illegal_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_imm_decode_stage : vector table, scoreboard and corner sequences
// Rev 1.0
// ============================================================================
module tb_imm_decode_stage;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // XLEN=32, CNT_W=16 instance
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, out_imm;
   logic [2:0]  out_imm_type, out_funct3;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic        out_sh_arith, out_illegal;
   logic [15:0] illegal_cnt;

   // XLEN=64, CNT_W=2 instance
   logic        x_flush, x_in_valid, x_in_ready, x_out_valid, x_out_ready;
   logic [31:0] x_in_inst;
   logic [63:0] x_in_pc, x_out_pc, x_out_imm;
   logic [2:0]  x_out_imm_type, x_out_funct3;
   logic [6:0]  x_out_opcode;
   logic [4:0]  x_out_rd, x_out_rs1, x_out_rs2;
   logic        x_out_sh_arith, x_out_illegal;
   logic [1:0]  x_illegal_cnt;

   imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
      .out_imm_type(out_imm_type), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_sh_arith(out_sh_arith), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(x_flush),
      .in_valid(x_in_valid), .in_ready(x_in_ready), .in_inst(x_in_inst), .in_pc(x_in_pc),
      .out_valid(x_out_valid), .out_ready(x_out_ready), .out_pc(x_out_pc), .out_imm(x_out_imm),
      .out_imm_type(x_out_imm_type), .out_opcode(x_out_opcode), .out_funct3(x_out_funct3),
      .out_rd(x_out_rd), .out_rs1(x_out_rs1), .out_rs2(x_out_rs2),
      .out_sh_arith(x_out_sh_arith), .out_illegal(x_out_illegal), .illegal_cnt(x_illegal_cnt)
   );

   typedef struct {
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  typ;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        sh;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm;
      logic [2:0]  typ;
      logic        ill;
      logic        sh;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: immediates computed as signed integer values from the
   // instruction-set rules, then reduced modulo 2^XLEN.
   function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
      exp_t       e;
      longint     v;
      int         t;
      bit         bad;
      bit         shift;
      int         n;
      logic [6:0] op;
      logic [2:0] f3;
      op    = inst[6:0];
      f3    = inst[14:12];
      v     = 0;
      t     = 0;
      bad   = 0;
      shift = 0;
      case (op)
         7'h37, 7'h17: begin
            t = 4;
            v = longint'({inst[31:12], 12'h000});
            if (inst[31]) v = v - (longint'(1) << 32);
         end
         7'h6F: begin
            t = 5;
            v = longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            if (inst[31]) v = v - (longint'(1) << 21);
         end
         7'h67, 7'h03, 7'h0F: begin
            t = 1;
            v = longint'(inst[31:20]);
            if (inst[31]) v = v - 4096;
         end
         7'h23: begin
            t = 2;
            v = longint'({inst[31:25], inst[11:7]});
            if (inst[31]) v = v - 4096;
         end
         7'h63: begin
            t = 3;
            v = longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            if (inst[31]) v = v - 8192;
         end
         7'h13, 7'h1B: begin
            if (op == 7'h1B && !x64) begin
               bad = 1;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
               shift = 1;
               t = 6;
               n = (x64 && op == 7'h13) ? 6 : 5;
               v = longint'(inst[25:20]) % (longint'(1) << n);
               if (inst[31] || inst[29:26] != 4'd0 || (n == 5 && inst[25])) bad = 1;
            end else begin
               t = 1;
               v = longint'(inst[31:20]);
               if (inst[31]) v = v - 4096;
            end
         end
         7'h33: t = 0;
         7'h3B: if (!x64) bad = 1;
         7'h73: begin
            if (f3[2]) begin
               t = 7;
               v = longint'(inst[19:15]);
            end else begin
               t = 1;
               v = longint'(inst[31:20]);
               if (inst[31]) v = v - 4096;
            end
         end
         default: bad = 1;
      endcase
      if (inst[1:0] != 2'b11) bad = 1;
      if (bad) begin
         t = 0;
         v = 0;
      end
      e.pc  = pc;
      e.imm = x64 ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
      e.typ = 3'(t);
      e.ill = bad;
      e.sh  = shift && !bad && inst[30];
      e.opc = inst[6:0];
      e.f3  = inst[14:12];
      e.rd  = inst[11:7];
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [13];
      logic [31:0] w;
      int          k;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
              7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73};
      w = $urandom;
      k = $urandom_range(0, 15);
      if (k < 13) w[6:0] = ops[k];
      if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1) begin
         w[31]    = 1'b0;
         w[29:25] = 5'd0;
      end
      return w;
   endfunction

   task automatic cmp32(input string tag, input exp_t e);
      check({tag, ".pc"},   64'(out_pc),       e.pc);
      check({tag, ".imm"},  64'(out_imm),      e.imm);
      check({tag, ".type"}, 64'(out_imm_type), 64'(e.typ));
      check({tag, ".ill"},  64'(out_illegal),  64'(e.ill));
      check({tag, ".sh"},   64'(out_sh_arith), 64'(e.sh));
      check({tag, ".opc"},  64'(out_opcode),   64'(e.opc));
      check({tag, ".f3"},   64'(out_funct3),   64'(e.f3));
      check({tag, ".rd"},   64'(out_rd),       64'(e.rd));
      check({tag, ".rs1"},  64'(out_rs1),      64'(e.rs1));
      check({tag, ".rs2"},  64'(out_rs2),      64'(e.rs2));
   endtask

   vec_t vt  [18];
   vec_t vt64[8];
   exp_t q [$];
   exp_t e;
   int   sent, got, guard;

   initial begin
      vt[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, 1'b0};
      vt[1]  = '{32'h4030D093, 64'h0000_0003, 3'd6, 1'b0, 1'b1};
      vt[2]  = '{32'h4230D093, 64'h0000_0000, 3'd0, 1'b1, 1'b0};
      vt[3]  = '{32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0, 1'b0};
      vt[4]  = '{32'h123450B7, 64'h1234_5000, 3'd4, 1'b0, 1'b0};
      vt[5]  = '{32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 1'b0, 1'b0};
      vt[6]  = '{32'hFF9FF0EF, 64'hFFFF_FFF8, 3'd5, 1'b0, 1'b0};
      vt[7]  = '{32'h3002D073, 64'h0000_0005, 3'd7, 1'b0, 1'b0};
      vt[8]  = '{32'h30029073, 64'h0000_0300, 3'd1, 1'b0, 1'b0};
      vt[9]  = '{32'h002081B3, 64'h0000_0000, 3'd0, 1'b0, 1'b0};
      vt[10] = '{32'h00000001, 64'h0000_0000, 3'd0, 1'b1, 1'b0};
      vt[11] = '{32'h0000007F, 64'h0000_0000, 3'd0, 1'b1, 1'b0};
      vt[12] = '{32'hFFF0809B, 64'h0000_0000, 3'd0, 1'b1, 1'b0};
      vt[13] = '{32'h0000003B, 64'h0000_0000, 3'd0, 1'b1, 1'b0};
      vt[14] = '{32'h00309093, 64'h0000_0003, 3'd6, 1'b0, 1'b0};
      vt[15] = '{32'hFFFFF117, 64'hFFFF_F000, 3'd4, 1'b0, 1'b0};
      vt[16] = '{32'h0FF0000F, 64'h0000_00FF, 3'd1, 1'b0, 1'b0};
      vt[17] = '{32'h80109093, 64'h0000_0000, 3'd0, 1'b1, 1'b0};

      vt64[0] = '{32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 1'b0};
      vt64[1] = '{32'h03F09093, 64'h0000_0000_0000_003F, 3'd6, 1'b0, 1'b0};
      vt64[2] = '{32'h4030D093, 64'h0000_0000_0000_0003, 3'd6, 1'b0, 1'b1};
      vt64[3] = '{32'h4230D093, 64'h0000_0000_0000_0023, 3'd6, 1'b0, 1'b1};
      vt64[4] = '{32'h4230D09B, 64'h0000_0000_0000_0000, 3'd0, 1'b1, 1'b0};
      vt64[5] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b0};
      vt64[6] = '{32'h0000003B, 64'h0000_0000_0000_0000, 3'd0, 1'b0, 1'b0};
      vt64[7] = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b0};

      flush = 0; in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 0;
      x_flush = 0; x_in_valid = 0; x_in_inst = '0; x_in_pc = '0; x_out_ready = 0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_imm",   64'(out_imm),   64'd0);
      check("rst.out_pc",    64'(out_pc),    64'd0);
      check("rst.cnt",       64'(illegal_cnt), 64'd0);
      rst_n = 1'b1;
      step();
      check("rst.in_ready",  64'(in_ready),  64'd1);
      check("rst.x_in_ready", 64'(x_in_ready), 64'd1);

      // ---------------- vector table, XLEN=32 ----------------
      out_ready = 1;
      for (int i = 0; i < 18; i++) begin
         in_valid = 1;
         in_inst  = vt[i].inst;
         in_pc    = 32'h1000 + 32'(4 * i);
         if (vt[i].ill) exp_cnt = exp_cnt + 16'd1;
         step();
         check($sformatf("vec%0d.valid", i), 64'(out_valid),    64'd1);
         check($sformatf("vec%0d.pc", i),    64'(out_pc),       64'(32'h1000 + 32'(4 * i)));
         check($sformatf("vec%0d.imm", i),   64'(out_imm),      vt[i].imm);
         check($sformatf("vec%0d.type", i),  64'(out_imm_type), 64'(vt[i].typ));
         check($sformatf("vec%0d.ill", i),   64'(out_illegal),  64'(vt[i].ill));
         check($sformatf("vec%0d.sh", i),    64'(out_sh_arith), 64'(vt[i].sh));
         check($sformatf("vec%0d.rd", i),    64'(out_rd),       64'(vt[i].inst[11:7]));
         check($sformatf("vec%0d.cnt", i),   64'(illegal_cnt),  64'(exp_cnt));
      end
      in_valid = 0;
      step();
      check("vec.drain_valid", 64'(out_valid), 64'd0);

      // ---------------- XLEN=64 / CNT_W=2 ----------------
      x_out_ready = 1;
      for (int k = 1; k <= 5; k++) begin
         x_in_valid = 1;
         x_in_inst  = 32'h0000_0000;
         x_in_pc    = 64'h8000_0000_0000_0000 + 64'(k);
         step();
         check($sformatf("sat%0d.cnt", k), 64'(x_illegal_cnt), 64'((k < 3) ? k : 3));
         check($sformatf("sat%0d.ill", k), 64'(x_out_illegal), 64'd1);
      end
      for (int i = 0; i < 8; i++) begin
         x_in_valid = 1;
         x_in_inst  = vt64[i].inst;
         x_in_pc    = 64'hFFFF_0000_0000_0000 + 64'(8 * i);
         step();
         check($sformatf("v64_%0d.pc", i),   x_out_pc, 64'hFFFF_0000_0000_0000 + 64'(8 * i));
         check($sformatf("v64_%0d.imm", i),  x_out_imm, vt64[i].imm);
         check($sformatf("v64_%0d.type", i), 64'(x_out_imm_type), 64'(vt64[i].typ));
         check($sformatf("v64_%0d.ill", i),  64'(x_out_illegal),  64'(vt64[i].ill));
         check($sformatf("v64_%0d.sh", i),   64'(x_out_sh_arith), 64'(vt64[i].sh));
      end
      x_in_valid = 0;
      step();
      check("v64.cnt_held", 64'(x_illegal_cnt), 64'd3);

      // ---------------- back-pressure ----------------
      out_ready = 0;
      in_valid  = 1; in_inst = 32'hFFF00093; in_pc = 32'h100;
      step();
      check("bp.a_valid", 64'(out_valid), 64'd1);
      check("bp.a_pc",    64'(out_pc),    64'h100);
      check("bp.ready1",  64'(in_ready),  64'd1);
      in_inst = 32'h123450B7; in_pc = 32'h104;
      step();
      check("bp.hold_pc", 64'(out_pc),    64'h100);
      check("bp.ready0",  64'(in_ready),  64'd0);
      in_inst = 32'hFE000EE3; in_pc = 32'h108;
      step();
      check("bp.c_refused_pc", 64'(out_pc),   64'h100);
      check("bp.c_refused_rd", 64'(in_ready), 64'd0);
      in_valid = 0; out_ready = 1;
      step();
      check("bp.b_valid", 64'(out_valid), 64'd1);
      check("bp.b_pc",    64'(out_pc),    64'h104);
      check("bp.b_imm",   64'(out_imm),   64'h1234_5000);
      check("bp.ready_back", 64'(in_ready), 64'd1);
      step();
      check("bp.empty", 64'(out_valid), 64'd0);

      // ---------------- flush ----------------
      out_ready = 0;
      in_valid = 1; in_inst = 32'hFFF00093; in_pc = 32'h200;
      step();
      in_inst = 32'h0000_0000; in_pc = 32'h204;
      exp_cnt = exp_cnt + 16'd1;
      step();
      check("fl.full",     64'(in_ready),    64'd0);
      check("fl.cnt_pre",  64'(illegal_cnt), 64'(exp_cnt));
      flush = 1; in_inst = 32'h0000_0000; in_pc = 32'h208;
      step();
      check("fl.valid0",   64'(out_valid),   64'd0);
      check("fl.ready1",   64'(in_ready),    64'd1);
      check("fl.cnt",      64'(illegal_cnt), 64'(exp_cnt));
      in_pc = 32'h20C;
      step();
      check("fl.in_drop",  64'(out_valid),   64'd0);
      check("fl.cnt2",     64'(illegal_cnt), 64'(exp_cnt));
      flush = 0; in_valid = 0; out_ready = 1;
      step();
      check("fl.no_ghost", 64'(out_valid),   64'd0);
      in_valid = 1; in_inst = 32'h00309093; in_pc = 32'h210;
      step();
      check("fl.next_pc",  64'(out_pc),      64'h210);
      in_valid = 0;
      step();

      // ---------------- randomized scoreboard ----------------
      sent = 0; got = 0; guard = 0;
      while ((sent < 1000 || q.size() != 0) && guard < 20000) begin
         guard++;
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = (sent >= 1000) || ($urandom_range(0, 2) != 0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rand.extra: got pc 0x%0h expected no entry", out_pc);
            end else begin
               e = q.pop_front();
               cmp32($sformatf("rand%0d", got), e);
               got++;
            end
         end
         if (in_valid && in_ready) begin
            e = model(in_inst, 64'(in_pc), 1'b0);
            q.push_back(e);
            sent++;
            if (e.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
         step();
      end
      in_valid = 0;
      check("rand.left",  64'(q.size()),    64'd0);
      check("rand.got",   64'(got),         64'd1000);
      check("rand.cnt",   64'(illegal_cnt), 64'(exp_cnt));
      step();
      check("rand.empty", 64'(out_valid),   64'd0);

      // ---------------- async reset mid-stall ----------------
      out_ready = 0; x_out_ready = 0;
      in_valid = 1; in_inst = 32'hFFF00093; in_pc = 32'h300;
      x_in_valid = 1; x_in_inst = 32'hFFF0809B; x_in_pc = 64'h300;
      step();
      in_pc = 32'h304; x_in_pc = 64'h304;
      step();
      in_valid = 0; x_in_valid = 0;
      check("ar.stalled", 64'(in_ready), 64'd0);
      #3 rst_n = 1'b0;
      #1;
      check("ar.valid",   64'(out_valid),     64'd0);
      check("ar.pc",      64'(out_pc),        64'd0);
      check("ar.imm",     64'(out_imm),       64'd0);
      check("ar.rd",      64'(out_rd),        64'd0);
      check("ar.cnt",     64'(illegal_cnt),   64'd0);
      check("ar.x_valid", 64'(x_out_valid),   64'd0);
      check("ar.x_imm",   x_out_imm,          64'd0);
      check("ar.x_cnt",   64'(x_illegal_cnt), 64'd0);
      #2 rst_n = 1'b1;
      step();
      check("ar.in_ready",  64'(in_ready),  64'd1);
      check("ar.valid_post", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
